tetris_playfield: RTL and testbench
===================================

# tetris_playfield

Parametrised playfield engine for the Tetris display design. It holds the board occupancy grid and the falling piece, and applies gravity, move, rotate and hard-drop commands with collision checking. It locks landed pieces, clears full rows with a score update, and flags game over. Its flat board and piece outputs feed the pixel renderer, which converts the grid to colour at display resolution; the engine itself works purely in cell coordinates.

## Interface
- BOARD_W, 10, board columns (min 2)
- BOARD_H, 20, board rows (min 3); row 0 is top
- SCORE_W, 8, score counter width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle gravity strobe (e.g. per frame divider)
- mv_left  in  1  one-cycle move-left command
- mv_right  in  1  one-cycle move-right command
- rotate  in  1  one-cycle rotate command
- drop  in  1  one-cycle hard-drop command
- restart  in  1  one-cycle new-game command
- board  out  BOARD_W*BOARD_H  occupancy, bit r*BOARD_W+c
- piece_x  out  clog2(BOARD_W)  piece box column (left)
- piece_y  out  clog2(BOARD_H)  piece box row (top)
- piece_mask  out  6  active piece, bit r*2+c of 2-col x 3-row box
- score  out  SCORE_W  rows cleared, saturating
- game_over  out  1  high in OVER state
- busy  out  1  high when commands are ignored (not FALL)

## Operation
- Shapes (base <-> rotated, rotate toggles): L 111010<->010111, T 011101<->101110, Z 011110<->101101, I 101010<->010101. Spawn order L,T,Z,I repeating; next index increments mod 4 on each spawn.
- Collision: candidate (x,y,mask) collides if the box exceeds the board (x>BOARD_W-2 or y>BOARD_H-3, negative via underflow) or any set mask bit overlaps a set board bit. Evaluated combinationally.
- States: FALL, DROP, LOCK, CLEAR, SPAWN, OVER.
- FALL: one command per cycle, priority restart > drop > rotate > mv_left > mv_right > tick. Lower-priority inputs asserted in the same cycle are discarded. Move/rotate applies next edge only if the candidate is collision-free, otherwise no change. A collision-free tick sets y+1. A colliding tick goes to LOCK.
- DROP: y+1 each cycle while y+1 is free; first blocked cycle -> LOCK. Inputs ignored except restart.
- LOCK: OR mask cells into board (1 cycle), row index := BOARD_H-1 -> CLEAR.
- CLEAR: one row examined per cycle. If full: all rows above shift down one, row 0 cleared, score+1 (saturate at all-ones), row index unchanged (re-examine). Else index-1. After row 0 is examined and not full -> SPAWN.
- SPAWN: mask := next shape, x := (BOARD_W-2)/2, y := 0. If collision -> OVER (piece still output), else FALL.
- OVER: holds all state; only restart acts.
- restart (any state): same effect as reset.

## Timing
- Reset/restart values: board 0, score 0, game_over 0, busy 0, piece_mask 111010, piece_x (BOARD_W-2)/2, piece_y 0, state FALL, next index 1.
- Move/rotate/tick: outputs update on the edge after the command cycle (latency 1).
- Lock to new piece: 1 (LOCK) + BOARD_H + k (k = full rows) + 1 (SPAWN) cycles.
- Commands during busy are dropped, not queued.
- reset mid-CLEAR or mid-DROP: partial shift is discarded and the board is zeroed.

## Test plan
- Reset, BOARD_W=10: mask 111010, piece_x 4, piece_y 0, score 0, busy 0; mv_left x3 -> piece_x 1.
- BOARD_W=4: mv_right x5 -> piece_x saturates at 2. rotate at x=2 -> mask 010111 (in bounds).
- BOARD_W=2, BOARD_H=6: drop -> L reaches y=3. After LOCK+CLEAR, row 5 is cleared, score 1, and board bits 9 and 11 are set (c1 in rows 4 and 5). Next piece is mask 011101 at x 0, y 0.
- Simultaneous rotate+tick+mv_left in FALL -> only rotate applied, piece_y unchanged.
- BOARD_W=2, BOARD_H=3: first drop locks at y 0. Next spawn collides -> game_over 1, busy 1. tick/mv ignored; restart -> game_over 0, board 0.
- Ticks while busy in CLEAR -> no y change. Score at 2^SCORE_W-1 plus a clear -> stays saturated.

Source files
------------

// File: rtl/tetris_playfield.sv
// Tetris playfield engine: occupancy grid plus one falling piece in a 2x3 box.
// Handles gravity, moves, rotation, hard drop, locking, row clearing and game over.
module tetris_playfield #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SCORE_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         mv_left,
    input  logic                         mv_right,
    input  logic                         rotate,
    input  logic                         drop,
    input  logic                         restart,
    output logic [BOARD_W*BOARD_H-1:0]   board,
    output logic [$clog2(BOARD_W)-1:0]   piece_x,
    output logic [$clog2(BOARD_H)-1:0]   piece_y,
    output logic [5:0]                   piece_mask,
    output logic [SCORE_W-1:0]           score,
    output logic                         game_over,
    output logic                         busy
);
    localparam int N  = BOARD_W * BOARD_H;
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam int IW = $clog2(N);
    localparam logic [XW-1:0]      SPAWN_X   = XW'((BOARD_W - 2) / 2);
    localparam logic [XW-1:0]      X_ONE     = XW'(1);
    localparam logic [YW-1:0]      Y_ONE     = YW'(1);
    localparam logic [YW-1:0]      Y_LAST    = YW'(BOARD_H - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [2:0] {
        ST_FALL  = 3'd0,
        ST_DROP  = 3'd1,
        ST_LOCK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_SPAWN = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [N-1:0]         board_r, board_s, shifted_s;
    logic [XW-1:0]        x_r, x_s;
    logic [YW-1:0]        y_r, y_s, row_r, row_s;
    logic [5:0]           mask_r, mask_s;
    logic [1:0]           nidx_r, nidx_s;
    logic [SCORE_W-1:0]   score_r, score_s;
    logic                 busy_r, game_over_r, row_full_s;

    function automatic logic [5:0] shape_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    return 6'b111010;
            2'd1:    return 6'b011101;
            2'd2:    return 6'b011110;
            2'd3:    return 6'b101010;
            default: return 6'b111010;
        endcase
    endfunction

    function automatic logic [5:0] rot_mask(input logic [5:0] m);
        case (m)
            6'b111010: return 6'b010111;
            6'b010111: return 6'b111010;
            6'b011101: return 6'b101110;
            6'b101110: return 6'b011101;
            6'b011110: return 6'b101101;
            6'b101101: return 6'b011110;
            6'b101010: return 6'b010101;
            6'b010101: return 6'b101010;
            default:   return m;
        endcase
    endfunction

    function automatic logic [IW-1:0] cell_idx(input int row, input int col);
        return IW'(row * BOARD_W + col);
    endfunction

    // Out-of-box is detected first (an underflowed x/y reads as a huge value) so the board is never indexed out of range.
    function automatic logic collides(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                      input logic [5:0] m, input logic [N-1:0] b);
        logic hit;
        hit = 1'b0;
        if (int'(x) > BOARD_W - 2 || int'(y) > BOARD_H - 3) begin
            hit = 1'b1;
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 2; c++)
                    hit = hit | (m[r*2+c] & b[cell_idx(int'(y) + r, int'(x) + c)]);
        end
        return hit;
    endfunction

    function automatic logic [N-1:0] stamp(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                           input logic [5:0] m);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                if (m[r*2+c]) v[cell_idx(int'(y) + r, int'(x) + c)] = 1'b1;
        return v;
    endfunction

    // Next-state and datapath: one command per cycle in FALL, fixed sequencing elsewhere.
    always_comb begin
        state_s    = state_r;
        board_s    = board_r;
        x_s        = x_r;
        y_s        = y_r;
        mask_s     = mask_r;
        nidx_s     = nidx_r;
        row_s      = row_r;
        score_s    = score_r;
        row_full_s = 1'b1;
        shifted_s  = board_r;
        for (int c = 0; c < BOARD_W; c++)
            row_full_s = row_full_s & board_r[cell_idx(int'(row_r), c)];
        // Rows at or above the examined row move down one; row 0 refills empty.
        for (int r = 0; r < BOARD_H; r++) begin
            for (int c = 0; c < BOARD_W; c++) begin
                if (r == 0) begin
                    shifted_s[cell_idx(r, c)] = 1'b0;
                end else if (r <= int'(row_r)) begin
                    shifted_s[cell_idx(r, c)] = board_r[cell_idx(r - 1, c)];
                end else begin
                    shifted_s[cell_idx(r, c)] = board_r[cell_idx(r, c)];
                end
            end
        end
        case (state_r)
            ST_FALL: begin
                if (drop) begin
                    state_s = ST_DROP;
                end else if (rotate) begin
                    if (!collides(x_r, y_r, rot_mask(mask_r), board_r)) mask_s = rot_mask(mask_r);
                    else mask_s = mask_r;
                end else if (mv_left) begin
                    if (!collides(x_r - X_ONE, y_r, mask_r, board_r)) x_s = x_r - X_ONE;
                    else x_s = x_r;
                end else if (mv_right) begin
                    if (!collides(x_r + X_ONE, y_r, mask_r, board_r)) x_s = x_r + X_ONE;
                    else x_s = x_r;
                end else if (tick) begin
                    if (!collides(x_r, y_r + Y_ONE, mask_r, board_r)) y_s = y_r + Y_ONE;
                    else state_s = ST_LOCK;
                end else begin
                    state_s = ST_FALL;
                end
            end
            ST_DROP: begin
                if (!collides(x_r, y_r + Y_ONE, mask_r, board_r)) y_s = y_r + Y_ONE;
                else state_s = ST_LOCK;
            end
            ST_LOCK: begin
                board_s = board_r | stamp(x_r, y_r, mask_r);
                row_s   = Y_LAST;
                state_s = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (row_full_s) begin
                    board_s = shifted_s;
                    score_s = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_ONE;
                end else if (row_r == {YW{1'b0}}) begin
                    state_s = ST_SPAWN;
                end else begin
                    row_s = row_r - Y_ONE;
                end
            end
            ST_SPAWN: begin
                mask_s  = shape_mask(nidx_r);
                x_s     = SPAWN_X;
                y_s     = {YW{1'b0}};
                nidx_s  = nidx_r + 2'd1;
                state_s = collides(SPAWN_X, {YW{1'b0}}, shape_mask(nidx_r), board_r) ? ST_OVER : ST_FALL;
            end
            ST_OVER: begin
                state_s = ST_OVER;
            end
            default: begin
                state_s = ST_FALL;
            end
        endcase
    end

    // State and datapath registers; restart behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_r     <= ST_FALL;
            board_r     <= {N{1'b0}};
            x_r         <= SPAWN_X;
            y_r         <= {YW{1'b0}};
            mask_r      <= 6'b111010;
            nidx_r      <= 2'd1;
            row_r       <= {YW{1'b0}};
            score_r     <= {SCORE_W{1'b0}};
            busy_r      <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            board_r     <= board_s;
            x_r         <= x_s;
            y_r         <= y_s;
            mask_r      <= mask_s;
            nidx_r      <= nidx_s;
            row_r       <= row_s;
            score_r     <= score_s;
            busy_r      <= (state_s != ST_FALL);
            game_over_r <= (state_s == ST_OVER);
        end
    end

    assign board      = board_r;
    assign piece_x    = x_r;
    assign piece_y    = y_r;
    assign piece_mask = mask_r;
    assign score      = score_r;
    assign busy       = busy_r;
    assign game_over  = game_over_r;
endmodule

// File: tb/tb_tetris_playfield.sv
// Bench for tetris_playfield: a 10x20 and a 2x6 instance checked every cycle against a
// cell-level game model, plus hand-computed directed expectations.
module tb_tetris_playfield;
    localparam int AW = 10, AH = 20, AS = 8;
    localparam int BW = 2,  BH = 6,  BS = 2;
    localparam int S_FALL = 0, S_DROP = 1, S_LOCK = 2, S_CLEAR = 3, S_SPAWN = 4, S_OVER = 5;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] cmd_a, cmd_b;   // {restart, drop, rotate, mv_left, mv_right, tick}

    logic [AW*AH-1:0] board_a;
    logic [3:0]       x_a;
    logic [4:0]       y_a;
    logic [5:0]       mask_a;
    logic [AS-1:0]    score_a;
    logic             go_a, busy_a;
    logic [BW*BH-1:0] board_b;
    logic [0:0]       x_b;
    logic [2:0]       y_b;
    logic [5:0]       mask_b;
    logic [BS-1:0]    score_b;
    logic             go_b, busy_b;

    tetris_playfield #(.BOARD_W(AW), .BOARD_H(AH), .SCORE_W(AS)) u_a (
        .clk(clk), .reset(rst), .tick(cmd_a[0]), .mv_left(cmd_a[2]), .mv_right(cmd_a[1]),
        .rotate(cmd_a[3]), .drop(cmd_a[4]), .restart(cmd_a[5]),
        .board(board_a), .piece_x(x_a), .piece_y(y_a), .piece_mask(mask_a),
        .score(score_a), .game_over(go_a), .busy(busy_a));

    tetris_playfield #(.BOARD_W(BW), .BOARD_H(BH), .SCORE_W(BS)) u_b (
        .clk(clk), .reset(rst), .tick(cmd_b[0]), .mv_left(cmd_b[2]), .mv_right(cmd_b[1]),
        .rotate(cmd_b[3]), .drop(cmd_b[4]), .restart(cmd_b[5]),
        .board(board_b), .piece_x(x_b), .piece_y(y_b), .piece_mask(mask_b),
        .score(score_b), .game_over(go_b), .busy(busy_b));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Game model: board as a 2-D cell array, piece as (shape, rotation) into a shape table.
    bit mb [2][20][10];
    int mx [2], my [2], msh [2], mrot [2], mnext [2], mscore [2], mst [2], mrow [2];
    int pw [2] = '{AW, BW};
    int ph [2] = '{AH, BH};
    int ps [2] = '{AS, BS};
    logic [5:0] shp [4][2] = '{'{6'b111010, 6'b010111}, '{6'b011101, 6'b101110},
                               '{6'b011110, 6'b101101}, '{6'b101010, 6'b010101}};

    function automatic bit mhit(int k, int x, int y, logic [5:0] m);
        if (x < 0 || y < 0 || x > pw[k] - 2 || y > ph[k] - 3) return 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                if (m[r*2+c] && mb[k][y+r][x+c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic minit(int k);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) mb[k][r][c] = 1'b0;
        mx[k] = (pw[k] - 2) / 2; my[k] = 0; msh[k] = 0; mrot[k] = 0;
        mnext[k] = 1; mscore[k] = 0; mst[k] = S_FALL; mrow[k] = 0;
    endtask

    task automatic mstep(int k, bit r, logic [5:0] cmd);
        logic [5:0] m;
        bit full;
        if (r || cmd[5]) begin
            minit(k);
            return;
        end
        m = shp[msh[k]][mrot[k]];
        case (mst[k])
            S_FALL: begin
                if (cmd[4]) mst[k] = S_DROP;
                else if (cmd[3]) begin
                    if (!mhit(k, mx[k], my[k], shp[msh[k]][1-mrot[k]])) mrot[k] = 1 - mrot[k];
                end else if (cmd[2]) begin
                    if (!mhit(k, mx[k] - 1, my[k], m)) mx[k] = mx[k] - 1;
                end else if (cmd[1]) begin
                    if (!mhit(k, mx[k] + 1, my[k], m)) mx[k] = mx[k] + 1;
                end else if (cmd[0]) begin
                    if (!mhit(k, mx[k], my[k] + 1, m)) my[k] = my[k] + 1;
                    else mst[k] = S_LOCK;
                end
            end
            S_DROP: begin
                if (!mhit(k, mx[k], my[k] + 1, m)) my[k] = my[k] + 1;
                else mst[k] = S_LOCK;
            end
            S_LOCK: begin
                for (int rr = 0; rr < 3; rr++)
                    for (int c = 0; c < 2; c++)
                        if (m[rr*2+c]) mb[k][my[k]+rr][mx[k]+c] = 1'b1;
                mrow[k] = ph[k] - 1;
                mst[k] = S_CLEAR;
            end
            S_CLEAR: begin
                full = 1'b1;
                for (int c = 0; c < pw[k]; c++) if (!mb[k][mrow[k]][c]) full = 1'b0;
                if (full) begin
                    for (int rr = mrow[k]; rr > 0; rr--)
                        for (int c = 0; c < pw[k]; c++) mb[k][rr][c] = mb[k][rr-1][c];
                    for (int c = 0; c < pw[k]; c++) mb[k][0][c] = 1'b0;
                    if (mscore[k] < (1 << ps[k]) - 1) mscore[k] = mscore[k] + 1;
                end else if (mrow[k] == 0) mst[k] = S_SPAWN;
                else mrow[k] = mrow[k] - 1;
            end
            S_SPAWN: begin
                msh[k] = mnext[k]; mrot[k] = 0; mnext[k] = (mnext[k] + 1) % 4;
                mx[k] = (pw[k] - 2) / 2; my[k] = 0;
                mst[k] = mhit(k, mx[k], my[k], shp[msh[k]][0]) ? S_OVER : S_FALL;
            end
            default: ;
        endcase
    endtask

    function automatic logic [199:0] mflat(int k);
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < ph[k]; r++)
            for (int c = 0; c < pw[k]; c++) v[r*pw[k]+c] = mb[k][r][c];
        return v;
    endfunction

    task automatic cmp_one(input int k, input logic [199:0] ab, input int ax, input int ay,
                           input logic [5:0] am, input int asc, input logic ago, input logic abusy);
        logic [199:0] eb;
        logic [5:0] em;
        logic eg, ebz;
        eb = mflat(k);
        em = shp[msh[k]][mrot[k]];
        eg = (mst[k] == S_OVER);
        ebz = (mst[k] != S_FALL);
        n_chk++;
        if (ab == eb && ax == mx[k] && ay == my[k] && am == em && asc == mscore[k] && ago == eg && abusy == ebz)
            n_pass++;
        else
            $display("FAIL model_cmp[%0d] t=%0t board %h exp %h x %0d exp %0d y %0d exp %0d mask %b exp %b score %0d exp %0d go %b exp %b busy %b exp %b",
                     k, $time, ab, eb, ax, mx[k], ay, my[k], am, em, asc, mscore[k], ago, eg, abusy, ebz);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_one(0, board_a, int'(x_a), int'(y_a), mask_a, int'(score_a), go_a, busy_a);
            cmp_one(1, 200'(board_b), int'(x_b), int'(y_b), mask_b, int'(score_b), go_b, busy_b);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep(0, rst, cmd_a);
        mstep(1, rst, cmd_b);
        @(negedge clk);
    endtask

    task automatic wait_idle_b(input bit hold_tick, output int maxy);
        int n;
        n = 0;
        maxy = int'(y_b);
        while (busy_b && !go_b && n < 100) begin
            cmd_b = hold_tick ? 6'b000001 : 6'b000000;
            cyc();
            if (int'(y_b) > maxy) maxy = int'(y_b);
            n++;
        end
        cmd_b = 6'b000000;
        chk("wait_b_bound", longint'(n < 100), 1);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && !go_a && n < 200) begin
            cyc();
            n++;
        end
        chk("wait_a_bound", longint'(n < 200), 1);
    endtask

    function automatic logic [5:0] rnd_cmd();
        logic [5:0] c;
        c[5] = ($urandom_range(0, 149) == 0);
        c[4] = ($urandom_range(0, 11) == 0);
        c[3] = ($urandom_range(0, 5) == 0);
        c[2] = ($urandom_range(0, 4) == 0);
        c[1] = ($urandom_range(0, 4) == 0);
        c[0] = ($urandom_range(0, 2) == 0);
        return c;
    endfunction

    initial begin
        int maxy;
        rst = 1'b1;
        cmd_a = 6'b0;
        cmd_b = 6'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        chk("a_reset_mask", mask_a, 6'b111010);
        chk("a_reset_x", x_a, 4);
        chk("a_reset_y", y_a, 0);
        chk("a_reset_score", score_a, 0);
        chk("a_reset_busy", busy_a, 0);
        chk("a_reset_go", go_a, 0);
        chk("b_reset_x", x_b, 0);

        repeat (3) begin cmd_a = 6'b000100; cyc(); end
        cmd_a = 6'b0;
        chk("a_left3_x", x_a, 1);
        repeat (10) begin cmd_a = 6'b000010; cyc(); end
        cmd_a = 6'b0;
        chk("a_right_sat_x", x_a, 8);
        cmd_a = 6'b001101;
        cyc();
        cmd_a = 6'b0;
        chk("a_prio_mask", mask_a, 6'b010111);
        chk("a_prio_y", y_a, 0);
        chk("a_prio_x", x_a, 8);

        // Small board: L drops to y3, clears row 5, then the stack saturates score and tops out.
        cmd_b = 6'b010000; cyc(); cmd_b = 6'b0;
        wait_idle_b(1'b1, maxy);
        chk("b_p1_maxy", maxy, 3);
        chk("b_p1_board", board_b, 12'hA00);
        chk("b_p1_score", score_b, 1);
        chk("b_p1_mask", mask_b, 6'b011101);
        chk("b_p1_x", x_b, 0);
        chk("b_p1_y", y_b, 0);
        chk("b_p1_busy", busy_b, 0);
        cmd_b = 6'b010000; cyc(); cmd_b = 6'b0;
        wait_idle_b(1'b1, maxy);
        chk("b_p2_score", score_b, 3);
        cmd_b = 6'b010000; cyc(); cmd_b = 6'b0;
        wait_idle_b(1'b1, maxy);
        chk("b_p3_score_sat", score_b, 3);
        chk("b_p3_board", board_b, 12'h960);
        chk("b_over_go", go_b, 1);
        chk("b_over_busy", busy_b, 1);
        repeat (3) begin cmd_b = 6'b000101; cyc(); end
        cmd_b = 6'b0;
        chk("b_over_y", y_b, 0);
        chk("b_over_board", board_b, 12'h960);
        cmd_b = 6'b100000; cyc(); cmd_b = 6'b0;
        chk("b_restart_go", go_b, 0);
        chk("b_restart_board", board_b, 0);
        chk("b_restart_mask", mask_b, 6'b111010);

        // Large board: repeated drops at the spawn column stack up until game over.
        cmd_a = 6'b100000; cyc(); cmd_a = 6'b0;
        for (int p = 0; p < 30 && !go_a; p++) begin
            cmd_a = 6'b010000; cyc(); cmd_a = 6'b0;
            wait_idle_a();
        end
        chk("a_over_go", go_a, 1);
        chk("a_over_busy", busy_a, 1);
        repeat (3) begin cmd_a = 6'b000101; cyc(); end
        cmd_a = 6'b0;
        chk("a_over_x", x_a, 4);
        chk("a_over_y", y_a, 0);
        cmd_a = 6'b100000; cyc(); cmd_a = 6'b0;
        chk("a_restart_go", go_a, 0);
        chk("a_restart_board_zero", longint'(board_a == '0), 1);

        repeat (6000) begin
            rst = ($urandom_range(0, 1999) == 0);
            cmd_a = rnd_cmd();
            cmd_b = rnd_cmd();
            cyc();
        end
        rst = 1'b0;
        cmd_a = 6'b0;
        cmd_b = 6'b0;
        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
